fir_rns_sequencer: RTL

//  Frame-level controller for the RNS FIR datapath (fir_rns). Runs one frame at a time:

---
 rtl/rns_pkg.sv | 20 ++
 rtl/fir_rns_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rns_pkg.sv
// Shared RNS definitions for the FIR datapath and its sequencer: residue moduli,
// the filter operation encoding and the packed four-residue word type.
package rns_pkg;

  // Residue moduli, one per 8-bit lane of an RNS word {r3,r2,r1,r0}
  localparam int unsigned B0 = 251;
  localparam int unsigned B1 = 241;
  localparam int unsigned B2 = 239;
  localparam int unsigned B3 = 233;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_LOAD    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  typedef logic [31:0] rns_word_t;

endpackage

// File: rtl/fir_rns_sequencer.sv
// Frame controller for one fir_rns instance: clear, load SIGNAL_LEN samples,
// compute until the filter reports done, then drain the results to a
// valid/ready sink. Optional compute watchdog enabled by FIR_SEQ_TIMEOUT_EN.
module fir_rns_sequencer
  import rns_pkg::*;
#(
  parameter int TAPS        = 100,
  parameter int SIGNAL_LEN  = 1000,
  parameter int TIMEOUT_CYC = SIGNAL_LEN*(TAPS+1)+16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic        fir_reset,
  output logic [1:0]  fir_operation,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x_rns,
  input  logic [31:0] fir_y_rns,
  input  logic        fir_done
);

  localparam int CW = $clog2(SIGNAL_LEN+1);
  localparam logic [CW-1:0] LEN_W  = CW'(SIGNAL_LEN);
  localparam logic [CW-1:0] LAST_W = CW'(SIGNAL_LEN-1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    COMPUTE,
    READ
`ifdef FIR_SEQ_TIMEOUT_EN
    , ERROR
`endif
  } state_e;

  state_e          state_reg;
  logic [CW-1:0]   wr_cnt_reg;
  logic [CW-1:0]   rd_cnt_reg;
  logic            inflight_reg;
  logic            load_hs;
  logic            rd_issue;
  op_e             op_next;

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC+1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYC);
  logic [WDW-1:0]  wd_cnt_reg;
`endif

  // Filter length and watchdog limit only shape the default/optional watchdog
  logic unused_cfg;
  assign unused_cfg = TAPS[0] ^ TIMEOUT_CYC[0];

  assign load_hs  = (state_reg == LOAD) && in_valid && in_ready;
  assign rd_issue = (state_reg == READ) && (rd_cnt_reg < LEN_W) && !inflight_reg
                    && (!out_valid || out_ready);
  assign busy      = (state_reg != IDLE);
  assign fir_reset = reset || (state_reg == CLEAR);
  assign fir_operation = op_next;

  // Filter command decode: operation, address and write data follow state/counters
  always_comb begin
    op_next   = OP_NONE;
    fir_addr  = '0;
    fir_x_rns = '0;
    case (state_reg)
      LOAD: begin
        if (load_hs) begin
          op_next   = OP_LOAD;
          fir_addr  = 32'(wr_cnt_reg);
          fir_x_rns = in_data;
        end
      end
      COMPUTE: op_next = OP_COMPUTE;
      READ: begin
        if (rd_issue) begin
          op_next  = OP_READ;
          fir_addr = 32'(rd_cnt_reg);
        end
      end
      default: ;
    endcase
  end

  // Frame FSM with load/read counters and registered stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      inflight_reg <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
      wd_cnt_reg   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= CLEAR;
        end
        CLEAR: begin
          state_reg  <= LOAD;
          wr_cnt_reg <= '0;
          in_ready   <= 1'b1;
        end
        LOAD: begin
          if (load_hs) begin
            wr_cnt_reg <= wr_cnt_reg + CW'(1);
            if (wr_cnt_reg == LAST_W) begin
              in_ready  <= 1'b0;
              state_reg <= COMPUTE;
`ifdef FIR_SEQ_TIMEOUT_EN
              wd_cnt_reg <= '0;
`endif
            end
          end
        end
        COMPUTE: begin
          if (fir_done) begin
            state_reg    <= READ;
            rd_cnt_reg   <= '0;
            inflight_reg <= 1'b0;
          end
`ifdef FIR_SEQ_TIMEOUT_EN
          else if (wd_cnt_reg + WDW'(1) == WD_LIMIT) begin
            state_reg <= ERROR;
            err       <= 1'b1;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WDW'(1);
          end
`endif
        end
        READ: begin
          // Retire the current output; the last one closes the frame
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state_reg  <= IDLE;
              frame_done <= 1'b1;
            end
          end
          // Read data arrives one cycle after the issue; rd_cnt already points past it
          if (inflight_reg) begin
            out_data     <= fir_y_rns;
            out_valid    <= 1'b1;
            out_last     <= (rd_cnt_reg == LEN_W);
            inflight_reg <= 1'b0;
          end
          if (rd_issue) begin
            rd_cnt_reg   <= rd_cnt_reg + CW'(1);
            inflight_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
